// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Holds the fetch FSM state encoding, the buffered fetch entry and PC helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SQUASH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch targets may carry stray low bits; fetch is always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries between imem and decode.
// Flush wins over push/pop so a redirect always leaves the buffer empty.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from imem, buffers them for
// decode, squashes on redirect, and registers the BL link write toward r14.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   S_IDLE   | no request outstanding; issue from fetch_pc when buffer has room
//   S_WAIT   | request on req_addr outstanding; data will be kept
//   S_SQUASH | request outstanding but redirected; wait for ack, drop the data
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        link_valid,
    input  logic [31:0] link_value,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        r14_we,
    output logic [31:0] r14_wdata
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_addr_q;
    logic [31:0]   redirect_target;
    logic [31:0]   next_pc;

    logic          push;
    logic          pop;
    logic          flush;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] count_after_push;
    logic          space_after;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign redirect_target = align_word(redirect_pc);
    assign next_pc         = fetch_pc_q + WORD_BYTES;

    assign pop        = instr_valid && instr_ready;
    assign flush      = redirect_valid;
    assign push       = (state_q == S_WAIT) && imem_ack && !redirect_valid;
    assign push_entry = '{pc: req_addr_q, instr: imem_rdata};

    // Occupancy after this cycle's push and any pop decides whether the
    // next request can go out back-to-back.
    assign count_after_push = buf_count + CW'(1) - CW'(pop);
    assign space_after      = (count_after_push < CW'(BUF_DEPTH));

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                    end else if (!buf_full) begin
                        req_addr_q <= fetch_pc_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                        state_q    <= imem_ack ? S_IDLE : S_SQUASH;
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_pc;
                        if (space_after) begin
                            req_addr_q <= next_pc;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_SQUASH: begin
                    // req_addr stays put: the old request must complete on its own address.
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                    end
                    if (imem_ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r14_we    <= 1'b0;
            r14_wdata <= 32'h0000_0000;
        end else begin
            r14_we    <= link_valid;
            r14_wdata <= link_value;
        end
    end

    assign imem_req    = (state_q == S_WAIT) || (state_q == S_SQUASH);
    assign imem_addr   = req_addr_q;
    assign instr_valid = !buf_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect squash, link write,
// PC wrap and reset in the middle of a request.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_valid;
    logic [31:0] link_value;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        r14_we;
    logic [31:0] r14_wdata;

    logic        auto_ack;
    logic        man_ack;

    int vectors;
    int miscompares;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: zero-wait ack in auto mode, hand-driven otherwise.
    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = instr_of(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .link_valid     (link_valid),
        .link_value     (link_value),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .r14_we         (r14_we),
        .r14_wdata      (r14_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with rst_n just released and all inputs idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        auto_ack       = 1'b0;
        man_ack        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        link_valid     = 1'b0;
        link_value     = 32'h0;
        instr_ready    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; auto_ack = 1'b0; man_ack = 1'b0; redirect_valid = 1'b0;
        link_valid = 1'b0; link_value = 32'h0; instr_ready = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
        vectors++; if (r14_we !== 1'b0) begin miscompares++; $display("FAIL reset_r14_we: got %b want 0", r14_we); end
        vectors++; if (r14_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_r14_wdata: got %h want 00000000", r14_wdata); end
    endtask

    task automatic test_stream();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stream_first_req: got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_addr: got %h want 00000000", imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stream_fill_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid); end
            vectors++; if (instr_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc, 32'(4 * k)); end
            vectors++; if (instr !== instr_of(32'(4 * k))) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr, instr_of(32'(4 * k))); end
            vectors++; if (imem_addr !== 32'(4 * k + 4)) begin miscompares++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k + 4)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b0;
        tick();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
            vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h want 00000004", k, imem_addr); end
            vectors++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_head[%0d]: got v=%b pc=%h want v=1 pc=00000000", k, instr_valid, instr_pc); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin miscompares++; $display("FAIL stall_second: got v=%b pc=%h want v=1 pc=00000004", instr_valid, instr_pc); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req_full: got %b want 0", imem_req); end
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drained: got %b want 0", instr_valid); end
        tick();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin miscompares++; $display("FAIL stall_third: got v=%b pc=%h want v=1 pc=00000008", instr_valid, instr_pc); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rdw_req0: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rdw_squash_hold: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_dead: got req=%b v=%b want req=0 v=0", imem_req, instr_valid); end
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL rdw_new_req: got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rdw_no_old: got %b want 0", instr_valid); end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin miscompares++; $display("FAIL rdw_first_pc: got v=%b pc=%h want v=1 pc=00000100", instr_valid, instr_pc); end
        vectors++; if (instr !== instr_of(32'h100)) begin miscompares++; $display("FAIL rdw_first_instr: got %h want %h", instr, instr_of(32'h100)); end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        vectors++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL rap_setup: got v=%b req=%b want v=1 req=1", instr_valid, imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rap_flushed: got %b want 0", instr_valid); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rap_idle: got %b want 0", imem_req); end
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL rap_new_req: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
        tick();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin miscompares++; $display("FAIL rap_first_pc: got v=%b pc=%h want v=1 pc=00000200", instr_valid, instr_pc); end
    endtask

    task automatic test_link();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b1;
        tick();
        vectors++; if (r14_we !== 1'b0) begin miscompares++; $display("FAIL link_pre_we: got %b want 0", r14_we); end
        link_valid = 1'b1; link_value = 32'h1004;
        redirect_valid = 1'b1; redirect_pc = 32'h2003;
        tick();
        link_valid = 1'b0; link_value = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        vectors++; if (r14_we !== 1'b1) begin miscompares++; $display("FAIL link_we: got %b want 1", r14_we); end
        vectors++; if (r14_wdata !== 32'h1004) begin miscompares++; $display("FAIL link_wdata: got %h want 00001004", r14_wdata); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL link_flushed: got %b want 0", instr_valid); end
        tick();
        vectors++; if (r14_we !== 1'b0) begin miscompares++; $display("FAIL link_we_drop: got %b want 0", r14_we); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin miscompares++; $display("FAIL link_resume: got req=%b addr=%h want req=1 addr=00002000", imem_req, imem_addr); end
        tick();
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000) begin miscompares++; $display("FAIL link_first_pc: got v=%b pc=%h want v=1 pc=00002000", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL wrap_idle: got %b want 0", imem_req); end
        tick();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req_top: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        tick();
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_req_zero: got %h want 00000000", imem_addr); end
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_head: got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc); end
        tick();
        vectors++; if (instr_pc !== 32'h0 || instr !== instr_of(32'h0)) begin miscompares++; $display("FAIL wrap_next: got pc=%h instr=%h want pc=00000000 instr=%h", instr_pc, instr, instr_of(32'h0)); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        auto_ack = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        tick();
        auto_ack = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL rmw_setup: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
        rst_n = 1'b0; man_ack = 1'b1;
        tick();
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmw_reset_req: got req=%b addr=%h want req=0 addr=00000000", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL rmw_reset_head: got v=%b instr=%h pc=%h want v=0 instr=0 pc=0", instr_valid, instr, instr_pc); end
        rst_n = 1'b1;
        tick();
        man_ack = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmw_first_fetch: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_stale_ack: got %b want 0", instr_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        link_valid = 1'b0; link_value = 32'h0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_link();
        test_wrap();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
